handshake_ctrl_rr_arbiter: RTL

- Shares one downstream handshake channel (e.g. a constant generator or shared operator input) among NUM_REQ requester channels.
- Round-robin arbitration; the winner's data and its index go into a single registered output slot.
- Sits between multiple control/data producers and one shared resource. The index output lets the consumer route the result back to the winning requester.

---
 rtl/handshake_ctrl_rr_arbiter_pkg.sv | 20 ++
 rtl/handshake_ctrl_rr_arbiter_rr_priority_picker.sv | 34 +++
 rtl/handshake_ctrl_rr_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/handshake_ctrl_rr_arbiter_pkg.sv
// handshake_ctrl_rr_arbiter_pkg: shared sizing helpers and constants for the round-robin sharing controllers.
package handshake_ctrl_rr_arbiter_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_REQ = 4;
    localparam int RST_PTR = 0;

    typedef logic [idx_bits(DEF_NUM_REQ)-1:0] idx_t;

endpackage

// File: rtl/handshake_ctrl_rr_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first valid requester at or after ptr, with explicit wrap.
module rr_priority_picker
    import handshake_ctrl_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int IDX_WIDTH = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_valid,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic                 o_grant_valid,
    output logic [IDX_WIDTH-1:0] o_grant_idx
);

    int w_pos;
    logic [NUM_REQ-1:0] w_bits;

    // Scan from the farthest offset down so the closest valid requester wins last.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx = '0;
        w_pos = 0;
        w_bits = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_bits = i_valid >> w_pos;
            if (w_bits[0]) begin
                o_grant_valid = 1'b1;
                o_grant_idx = IDX_WIDTH'(w_pos);
            end
        end
    end

endmodule

// File: rtl/handshake_ctrl_rr_arbiter.sv
// handshake_ctrl_rr_arbiter: shares one registered output slot among NUM_REQ handshake requesters, round-robin.
module handshake_ctrl_rr_arbiter
    import handshake_ctrl_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ins,
    input  logic [NUM_REQ-1:0]            ins_valid,
    output logic [NUM_REQ-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]         outs,
    output logic [IDX_WIDTH-1:0]          index,
    output logic                          outs_valid,
    input  logic                          outs_ready
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic                  w_gv;
    logic [IDX_WIDTH-1:0]  w_gi;
    logic                  w_can_accept;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_sel;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .i_valid       (ins_valid),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_gv),
        .o_grant_idx   (w_gi)
    );

    assign w_can_accept = !r_full || outs_ready;
    assign w_xfer       = !rst && w_gv && w_can_accept;

    always_comb begin
        w_sel = '0;
        ins_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gi == IDX_WIDTH'(i)) begin
                w_sel = ins[i*DATA_WIDTH +: DATA_WIDTH];
                ins_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_idx  <= '0;
            r_ptr  <= IDX_WIDTH'(RST_PTR);
        end else if (w_xfer) begin
            r_full <= 1'b1;
            r_data <= w_sel;
            r_idx  <= w_gi;
            r_ptr  <= (w_gi == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_gi + IDX_WIDTH'(1);
        end else if (outs_ready) begin
            r_full <= 1'b0;
        end
    end

    assign outs       = r_data;
    assign index      = r_idx;
    assign outs_valid = r_full;

endmodule
